// File: rtl/colour_seq_detector.sv
// colour_seq_detector: Mealy detector for a run-time programmable colour pattern
// of up to MAX_LEN symbols, with overlap/non-overlap selection and a saturating
// match counter.
// Ports: clk/rst (sync, active-high); in_valid/in_sym symbol stream;
//        cfg_load/cfg_len/cfg_pattern pattern load; cfg_overlap live match mode;
//        match (combinational, same cycle as final symbol), match_count, depth, cfg_err.
module colour_seq_detector #(
    parameter int SYM_W   = 2,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [SYM_W-1:0]         in_sym,
    input  logic                     cfg_load,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic [MAX_LEN*SYM_W-1:0] cfg_pattern,
    input  logic                     cfg_overlap,
    output logic                     match,
    output logic [CNT_W-1:0]         match_count,
    output logic [LEN_W-1:0]         depth,
    output logic                     cfg_err
);

    localparam int PW = MAX_LEN * SYM_W;
    localparam int NL = 1 << LEN_W;

    // Power-up pattern: red, green, blue (symbol 0 first)
    localparam logic [PW-1:0]    PAT_RST = PW'({SYM_W'(2), SYM_W'(1), SYM_W'(0)});
    localparam logic [LEN_W-1:0] LEN_RST = LEN_W'(3);

    typedef enum logic {
        FILL,
        ARMED
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   depth_q, depth_d;
    logic [PW-1:0]      pat_q, pat_d;
    logic [PW-1:0]      hist_q, hist_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    // Candidate window: slot 0 is the symbol being presented, slot j+1 is history[j]
    logic [PW-1:0]      win;
    logic [NL-1:0]      len_hit;
    logic               hit;
    logic [LEN_W:0]     depth_inc;

    assign win = {hist_q[PW-SYM_W-1:0], in_sym};

    // Evaluate the window against the pattern for every legal length and pick
    // the active one; keeps all slice indices constant.
    always_comb begin
        len_hit = '0;
        for (int l = 2; l <= MAX_LEN; l++) begin
            len_hit[l] = 1'b1;
            for (int k = 0; k < l; k++) begin
                if (pat_q[k*SYM_W +: SYM_W] != win[(l-1-k)*SYM_W +: SYM_W]) begin
                    len_hit[l] = 1'b0;
                end
            end
        end
    end

    assign hit = len_hit[len_q];

    // Next-state and Mealy output
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        depth_d   = depth_q;
        pat_d     = pat_q;
        hist_d    = hist_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        match     = 1'b0;
        depth_inc = '0;

        if (rst) begin
            len_d   = LEN_RST;
            pat_d   = PAT_RST;
            hist_d  = '0;
            depth_d = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else if (cfg_load) begin
            // Load wins over a coincident symbol, which is dropped
            len_d   = cfg_len;
            pat_d   = cfg_pattern;
            hist_d  = '0;
            depth_d = '0;
            cnt_d   = '0;
            err_d   = (cfg_len < LEN_W'(2)) || (cfg_len > LEN_W'(MAX_LEN));
        end else if (in_valid && !err_q) begin
            hist_d = {hist_q[PW-SYM_W-1:0], in_sym};
            match  = (state_q == ARMED) && hit;
            if (match) begin
                depth_d = cfg_overlap ? len_q : '0;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (depth_q >= len_q) begin
                depth_d = len_q;
            end else begin
                depth_d = depth_q + LEN_W'(1);
            end
        end

        // ARMED once depth reaches len-1; computed one bit wider so len = 0 cannot underflow
        depth_inc = {1'b0, depth_d} + (LEN_W+1)'(1);
        state_d   = (depth_inc >= {1'b0, len_d}) ? ARMED : FILL;
    end

    // Reset is folded into the next-state logic, so every register follows it
    always_ff @(posedge clk) begin
        state_q <= state_d;
        len_q   <= len_d;
        depth_q <= depth_d;
        pat_q   <= pat_d;
        hist_q  <= hist_d;
        cnt_q   <= cnt_d;
        err_q   <= err_d;
    end

    assign match_count = cnt_q;
    assign depth       = depth_q;
    assign cfg_err     = err_q;

endmodule
